// File: rtl/ping_pong_drain_pkg.sv
// Shared types and default sizes for the ping-pong result drain.
// Optional statistics are enabled with the PING_PONG_DRAIN_STATS_EN macro (see ping_pong_drain).
package ping_pong_pkg;

  localparam int NUM_INST_D    = 4;
  localparam int RES_WIDTH_D   = 64;
  localparam int DRAIN_DEPTH_D = 16;
  localparam int ADDR_WIDTH_D  = $clog2(DRAIN_DEPTH_D);

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_SEND  = 2'd2
  } drain_state_t;

  // One-hot mask of a bank index, used for bank_full set/clear vectors.
  function automatic logic [1:0] bank_onehot(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/pp_result_bank.sv
// Simple dual-port result bank: full-width write, registered read with one cycle latency.
module pp_result_bank
  import ping_pong_pkg::*;
#(
  parameter int WIDTH = NUM_INST_D * RES_WIDTH_D,
  parameter int DEPTH = DRAIN_DEPTH_D,
  parameter int AW    = ADDR_WIDTH_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register; reset so the stream word is zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/ping_pong_drain.sv
// Captures matmul result beats into two banks and streams a full bank out one lane word at a time.
// Define PING_PONG_DRAIN_STATS_EN to enable tile_cnt and the overflow $error.
module ping_pong_drain
  import ping_pong_pkg::*;
#(
  parameter int NUMBER_OF_BUFFER_INSTANCES = NUM_INST_D,
  parameter int RES_WIDTH                  = RES_WIDTH_D,
  parameter int DRAIN_DEPTH                = DRAIN_DEPTH_D
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  in_valid,
  input  logic [NUMBER_OF_BUFFER_INSTANCES-1:0][RES_WIDTH-1:0]  in_data,
  output logic                                                  in_ready,
  output logic                                                  out_valid,
  input  logic                                                  out_ready,
  output logic [RES_WIDTH-1:0]                                  out_data,
  output logic [$clog2(NUMBER_OF_BUFFER_INSTANCES)-1:0]         out_lane,
  output logic                                                  out_last,
  output logic [1:0]                                            bank_full,
  output logic                                                  overflow,
  output logic [15:0]                                           tile_cnt
);

  localparam int ADDR_WIDTH = $clog2(DRAIN_DEPTH);
  localparam int LANE_W     = $clog2(NUMBER_OF_BUFFER_INSTANCES);
  localparam int ROW_W      = NUMBER_OF_BUFFER_INSTANCES * RES_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DRAIN_DEPTH - 1);
  localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(NUMBER_OF_BUFFER_INSTANCES - 1);

  logic                  wr_bank_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  rd_bank_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [LANE_W-1:0]     rd_lane_r;
  logic [1:0]            bank_full_r;
  logic [LANE_W-1:0]     out_lane_r;
  logic                  out_last_r;
  logic                  overflow_r;
  drain_state_t          state_r;
  drain_state_t          state_s;

  logic       accept_s;
  logic       hs_s;
  logic       last_word_s;
  logic [1:0] set_s;
  logic [1:0] clr_s;
  logic [NUMBER_OF_BUFFER_INSTANCES-1:0][RES_WIDTH-1:0] row0_s;
  logic [NUMBER_OF_BUFFER_INSTANCES-1:0][RES_WIDTH-1:0] row1_s;
  logic [NUMBER_OF_BUFFER_INSTANCES-1:0][RES_WIDTH-1:0] row_sel_s;

  assign in_ready    = !bank_full_r[wr_bank_r];
  assign accept_s    = in_valid && in_ready;
  assign hs_s        = (state_r == RD_SEND) && out_ready;
  assign last_word_s = (rd_addr_r == ADDR_LAST) && (rd_lane_r == LANE_LAST);
  // Write only fills a non-full bank and read only drains a full one, so set/clear never collide.
  assign set_s = (accept_s && (wr_addr_r == ADDR_LAST)) ? bank_onehot(wr_bank_r) : 2'b00;
  assign clr_s = (hs_s && last_word_s) ? bank_onehot(rd_bank_r) : 2'b00;

  pp_result_bank #(.WIDTH(ROW_W), .DEPTH(DRAIN_DEPTH), .AW(ADDR_WIDTH)) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept_s && !wr_bank_r),
    .waddr (wr_addr_r),
    .wdata (in_data),
    .re    ((state_r == RD_FETCH) && !rd_bank_r),
    .raddr (rd_addr_r),
    .rdata (row0_s)
  );

  pp_result_bank #(.WIDTH(ROW_W), .DEPTH(DRAIN_DEPTH), .AW(ADDR_WIDTH)) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept_s && wr_bank_r),
    .waddr (wr_addr_r),
    .wdata (in_data),
    .re    ((state_r == RD_FETCH) && rd_bank_r),
    .raddr (rd_addr_r),
    .rdata (row1_s)
  );

  assign row_sel_s = rd_bank_r ? row1_s : row0_s;
  assign out_data  = row_sel_s[out_lane_r];
  assign out_valid = (state_r == RD_SEND);
  assign out_lane  = out_lane_r;
  assign out_last  = out_last_r;
  assign bank_full = bank_full_r;
  assign overflow  = overflow_r;

  // Write pointer: address advances per beat, bank flips at the end of a tile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank_r <= 1'b0;
      wr_addr_r <= '0;
    end else if (accept_s) begin
      if (wr_addr_r == ADDR_LAST) begin
        wr_addr_r <= '0;
        wr_bank_r <= !wr_bank_r;
      end else begin
        wr_addr_r <= wr_addr_r + 1'b1;
      end
    end
  end

  // Bank full flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_full_r <= 2'b00;
      overflow_r  <= 1'b0;
    end else begin
      bank_full_r <= (bank_full_r | set_s) & ~clr_s;
      overflow_r  <= overflow_r | (in_valid && !in_ready);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read FSM next state; after a tile ends it goes straight to FETCH when the other bank waits.
  always_comb begin
    state_s = state_r;
    case (state_r)
      RD_IDLE: begin
        if (bank_full_r[rd_bank_r]) begin
          state_s = RD_FETCH;
        end else begin
          state_s = RD_IDLE;
        end
      end
      RD_FETCH: begin
        state_s = RD_SEND;
      end
      RD_SEND: begin
        if (!out_ready) begin
          state_s = RD_SEND;
        end else if (!last_word_s) begin
          state_s = RD_FETCH;
        end else if (bank_full_r[!rd_bank_r]) begin
          state_s = RD_FETCH;
        end else begin
          state_s = RD_IDLE;
        end
      end
      default: begin
        state_s = RD_IDLE;
      end
    endcase
  end

  // Read pointer (lane-minor, address-major) and registered lane/last tags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_bank_r  <= 1'b0;
      rd_addr_r  <= '0;
      rd_lane_r  <= '0;
      out_lane_r <= '0;
      out_last_r <= 1'b0;
    end else if (state_r == RD_FETCH) begin
      out_lane_r <= rd_lane_r;
      out_last_r <= last_word_s;
    end else if (hs_s) begin
      out_last_r <= 1'b0;
      if (last_word_s) begin
        rd_lane_r <= '0;
        rd_addr_r <= '0;
        rd_bank_r <= !rd_bank_r;
      end else if (rd_lane_r == LANE_LAST) begin
        rd_lane_r <= '0;
        rd_addr_r <= rd_addr_r + 1'b1;
      end else begin
        rd_lane_r <= rd_lane_r + 1'b1;
      end
    end
  end

`ifdef PING_PONG_DRAIN_STATS_EN
  logic [15:0] tile_cnt_r;

  // Count drained tiles; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_cnt_r <= 16'd0;
    end else if (hs_s && last_word_s) begin
      tile_cnt_r <= tile_cnt_r + 16'd1;
    end
  end

  // Report the first dropped beat after each reset.
  always_ff @(posedge clk) begin
    if (rst_n && in_valid && !in_ready && !overflow_r) begin
      $error("ping_pong_drain: capture beat dropped, both banks full");
    end
  end

  assign tile_cnt = tile_cnt_r;
`else
  assign tile_cnt = 16'd0;
`endif

endmodule
